// File: rtl/fib_arb_ctrl.sv
// ---------------------------------------------------------------------------
// fib_arb_ctrl
//
// Two-requester round-robin arbiter in front of an iterative Fibonacci engine.
// One request is served at a time: the winner's index is latched, the terms are
// stepped one per cycle, and the result comes back as a one-cycle strobe.
//
// Optional build macro:
//   FIB_SAT_EN - when defined, an overflowing result reads as 2^DATA_W-1
//                instead of F(idx) mod 2^DATA_W. rsp_ovf is the same either way.
//
// Parameters:
//   IDX_W   term-index width
//   DATA_W  result width
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req0/req1  requests, held high by the requester until granted
//   idx0/idx1  requested term index for each requester
//   gnt0/gnt1  one-cycle grant pulse
//   busy       high whenever the engine is not idle
//   rsp_valid  one-cycle result strobe
//   rsp_id     requester that owns the result
//   rsp_data   result value (held between strobes)
//   rsp_ovf    true term value does not fit in DATA_W bits (held between strobes)
// ---------------------------------------------------------------------------
module fib_arb_ctrl #(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [IDX_W-1:0]  idx0,
    input  logic [IDX_W-1:0]  idx1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [DATA_W-1:0]   a_r, a_s;
    logic [DATA_W-1:0]   b_r, b_s;
    // Sticky flags: the true value held in a / b no longer fits in DATA_W bits.
    logic                a_ovf_r, a_ovf_s;
    logic                b_ovf_r, b_ovf_s;
    logic [IDX_W-1:0]    cnt_r, cnt_s;
    logic                id_r, id_s;
    // Requester that wins when both request together.
    logic                prio_r, prio_s;
    logic                win_s;
    logic [DATA_W:0]     sum_s;
    logic                gnt0_s, gnt1_s, busy_s, rsp_valid_s, rsp_id_s, rsp_ovf_s;
    logic [DATA_W-1:0]   rsp_data_s;

    // Widened adder so the carry out of the term sum is visible.
    always_comb begin
        sum_s = {1'b0, a_r} + {1'b0, b_r};
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_s     = state_r;
        a_s         = a_r;
        b_s         = b_r;
        a_ovf_s     = a_ovf_r;
        b_ovf_s     = b_ovf_r;
        cnt_s       = cnt_r;
        id_s        = id_r;
        prio_s      = prio_r;
        win_s       = 1'b0;
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_id_s    = rsp_id;
        rsp_data_s  = rsp_data;
        rsp_ovf_s   = rsp_ovf;

        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    // Lone requester wins; on a tie the pointer decides.
                    win_s   = req1 && (!req0 || prio_r);
                    id_s    = win_s;
                    prio_s  = ~win_s;
                    gnt0_s  = ~win_s;
                    gnt1_s  = win_s;
                    a_s     = {DATA_W{1'b0}};
                    b_s     = DATA_W'(1);
                    a_ovf_s = 1'b0;
                    b_ovf_s = 1'b0;
                    cnt_s   = win_s ? idx1 : idx0;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r != {IDX_W{1'b0}}) begin
                    a_s     = b_r;
                    b_s     = sum_s[DATA_W-1:0];
                    // a inherits b's flag; b overflows if either term already
                    // had or the sum carries out.
                    a_ovf_s = b_ovf_r;
                    b_ovf_s = a_ovf_r | b_ovf_r | sum_s[DATA_W];
                    cnt_s   = cnt_r - IDX_W'(1);
                end else begin
                    state_s = DONE;
                end
            end
            DONE: begin
                rsp_valid_s = 1'b1;
                rsp_id_s    = id_r;
                rsp_ovf_s   = a_ovf_r;
`ifdef FIB_SAT_EN
                rsp_data_s  = a_ovf_r ? {DATA_W{1'b1}} : a_r;
`else
                rsp_data_s  = a_r;
`endif
                state_s     = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_r       <= {DATA_W{1'b0}};
            b_r       <= {DATA_W{1'b0}};
            a_ovf_r   <= 1'b0;
            b_ovf_r   <= 1'b0;
            cnt_r     <= {IDX_W{1'b0}};
            id_r      <= 1'b0;
            prio_r    <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= {DATA_W{1'b0}};
            rsp_ovf   <= 1'b0;
        end else begin
            state_r   <= state_s;
            a_r       <= a_s;
            b_r       <= b_s;
            a_ovf_r   <= a_ovf_s;
            b_ovf_r   <= b_ovf_s;
            cnt_r     <= cnt_s;
            id_r      <= id_s;
            prio_r    <= prio_s;
            gnt0      <= gnt0_s;
            gnt1      <= gnt1_s;
            busy      <= busy_s;
            rsp_valid <= rsp_valid_s;
            rsp_id    <= rsp_id_s;
            rsp_data  <= rsp_data_s;
            rsp_ovf   <= rsp_ovf_s;
        end
    end

endmodule

// File: tb/tb_fib_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fib_arb_ctrl
//
// Self-checking bench for fib_arb_ctrl with default parameters. Inputs are
// driven and outputs sampled on the falling clock edge. The reference model
// keeps only the round-robin pointer and computes Fibonacci terms with plain
// 64-bit arithmetic. Honours FIB_SAT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fib_arb_ctrl;

    localparam int IDX_W  = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0, req1;
    logic [IDX_W-1:0]  idx0, idx1;
    logic              gnt0, gnt1, busy, rsp_valid, rsp_id, rsp_ovf;
    logic [DATA_W-1:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;
    int prio    = 0;   // model: requester that wins a tie
    int last_id = 0;   // model: rsp_id/rsp_data must hold these between strobes
    int last_data = 0;

    fib_arb_ctrl #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .idx0      (idx0),
        .idx1      (idx1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint fib(input int n);
        longint x = 0;
        longint y = 1;
        longint t;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Serve one request. Call at a falling edge with req/idx already set; the
    // grant must appear one cycle later. Returns at the rsp_valid falling edge.
    task automatic serve();
        int     w;
        int     win;
        int     lat;
        int     idx_w;
        longint f;
        int     exp_d;
        int     exp_o;
        w = 1;
        @(negedge clk);
        while (!(gnt0 || gnt1) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("gnt_wait", w, 1);
        if (!(gnt0 || gnt1)) return;
        win = (req0 && req1) ? prio : (req0 ? 0 : 1);
        chk("gnt_both", gnt0 & gnt1, 0);
        chk("gnt_winner", gnt1, win);
        prio  = 1 - win;
        idx_w = win ? int'(idx1) : int'(idx0);
        if (win == 1) req1 = 1'b0;
        else          req0 = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            chk("busy_high", busy, 1);
            chk("hold_data", rsp_data, last_data);
            chk("hold_id", rsp_id, last_id);
            if (lat > 0) chk("gnt_while_busy", gnt0 | gnt1, 0);
            @(negedge clk);
            lat++;
        end
        f     = fib(idx_w);
        exp_o = (f > 255) ? 1 : 0;
`ifdef FIB_SAT_EN
        exp_d = exp_o ? 255 : int'(f % 256);
`else
        exp_d = int'(f % 256);
`endif
        chk("latency", lat, idx_w + 2);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_id", rsp_id, win);
        chk("rsp_ovf", rsp_ovf, exp_o);
        chk("busy_low_at_rsp", busy, 0);
        last_data = exp_d;
        last_id   = win;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        idx0  = '0;
        idx1  = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {gnt0, gnt1, busy, rsp_valid, rsp_id, rsp_ovf, rsp_data}, 0);
        rst_n = 1'b1;

        // Single request, idx 7 -> 13, grant on the first edge after reset.
        req0 = 1'b1; idx0 = 4'd7;
        serve();

        // Simultaneous pair then a third pair.
        req0 = 1'b1; idx0 = 4'd3; req1 = 1'b1; idx1 = 4'd5;
        serve();
        serve();
        req0 = 1'b1; idx0 = 4'd3; req1 = 1'b1; idx1 = 4'd2;
        serve();
        serve();

        // Boundary indices.
        for (int k = 0; k < 5; k++) begin
            req0 = 1'b1;
            case (k)
                0:       idx0 = 4'd0;
                1:       idx0 = 4'd1;
                2:       idx0 = 4'd13;
                3:       idx0 = 4'd14;
                default: idx0 = 4'd15;
            endcase
            serve();
        end

        // Reset three cycles into a long computation.
        req0 = 1'b1; idx0 = 4'd10;
        @(negedge clk);
        chk("midrst_gnt", gnt0, 1);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {gnt0, gnt1, busy, rsp_valid, rsp_id, rsp_ovf, rsp_data}, 0);
        prio = 0; last_id = 0; last_data = 0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("midrst_no_rsp", seen, 0);
        req0 = 1'b1; idx0 = 4'd4;
        serve();

        // Randomised traffic; held requests keep their index until granted.
        for (int t = 0; t < 40; t++) begin
            if (!req0 && $urandom_range(0, 1) == 1) begin
                req0 = 1'b1; idx0 = IDX_W'($urandom);
            end
            if (!req1 && $urandom_range(0, 1) == 1) begin
                req1 = 1'b1; idx1 = IDX_W'($urandom);
            end
            if (!req0 && !req1) begin
                req0 = 1'b1; idx0 = IDX_W'($urandom);
            end
            serve();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
